// File: rtl/counter_arbiter_if.sv
// Bundle of counter_arbiter per-channel event/clear inputs and count/status outputs.
// The master side produces events and clears; the slave side (the arbiter) returns counts and flags.
interface counter_arbiter_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  logic [CH-1:0]   evt;
  logic [CH-1:0]   clear;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   grant;
  logic [CH-1:0]   overflow;
  logic [CH-1:0]   drop;

  modport master (output evt, clear, input count, grant, overflow, drop);
  modport slave  (input evt, clear, output count, grant, overflow, drop);
endinterface

// File: rtl/counter_arbiter.sv
// CH event counters sharing one increment path, with per-channel pending buffers and a round-robin scheduler.
// Define COUNTER_ARB_FIXED_PRIO_EN to select fixed lowest-index-first priority instead of round-robin.
module counter_arbiter #(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int PW = 4
) (
  input logic              clk,
  input logic              rst,
  counter_arbiter_if.slave bus
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [PW-1:0] PEND_MAX = '1;

  logic [W-1:0]  count_q [CH];
  logic [PW-1:0] pend_q  [CH];
  logic [CH-1:0] grant_q, ovf_q, drop_q;

  logic [CH-1:0] eligible;
  logic [CH-1:0] svc;
  logic          sel_valid;
  logic [IW-1:0] sel;

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last_q;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    idx       = 0;
    sel_valid = 1'b0;
    sel       = '0;
    for (int i = 0; i < CH; i++) eligible[i] = (pend_q[i] != '0) && !bus.clear[i];
`ifdef COUNTER_ARB_FIXED_PRIO_EN
    for (int i = CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_valid = 1'b1;
        sel       = IW'(i);
      end
    end
`else
    // Walk from farthest to nearest so the channel right after last wins.
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(last_q) + k) % CH;
      if (eligible[idx]) begin
        sel_valid = 1'b1;
        sel       = IW'(idx);
      end
    end
`endif
    svc = sel_valid ? (CH'(1) << sel) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they take the async reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        count_q[i] <= '0;
        pend_q[i]  <= '0;
      end
      grant_q <= '0;
      ovf_q   <= '0;
      drop_q  <= '0;
    end else begin
      grant_q <= svc;
      for (int i = 0; i < CH; i++) begin
        if (bus.clear[i]) begin
          count_q[i] <= '0;
          pend_q[i]  <= '0;
          ovf_q[i]   <= 1'b0;
          drop_q[i]  <= 1'b0;
        end else begin
          if (svc[i]) begin
            count_q[i] <= count_q[i] + W'(1);
            if (count_q[i] == '1) ovf_q[i] <= 1'b1;
          end
          // Event and service together leave pending unchanged.
          if (bus.evt[i] && !svc[i]) begin
            if (pend_q[i] == PEND_MAX) drop_q[i] <= 1'b1;
            else                       pend_q[i] <= pend_q[i] + PW'(1);
          end else if (!bus.evt[i] && svc[i]) begin
            pend_q[i] <= pend_q[i] - PW'(1);
          end
        end
      end
    end
  end

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_q <= IW'(CH - 1);
    else if (sel_valid) last_q <= sel;
  end
`endif

  for (genvar g = 0; g < CH; g++) begin : g_count
    assign bus.count[g*W +: W] = count_q[g];
  end

  assign bus.grant    = grant_q;
  assign bus.overflow = ovf_q;
  assign bus.drop     = drop_q;
endmodule
